// File: rtl/spi_flash_stream.sv
// spi_flash_stream: SPI flash read engine (cmd 0x03, optional 0x3B dual read) streaming DATA_W-bit words.
// Latency: 32 (+8 dummy) SCK cycles of command/address, then one word per DATA_W (DATA_W/2 dual) SCKs.
// Backpressure: one-word output buffer plus shift register; SCK parks low at a word boundary while both are full.
// Optional feature macro: SPI_FLASH_STREAM_DUAL_EN (adds dual_mode input and the dual-output read path).
`timescale 1ns/1ps
module spi_flash_stream #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [23:0]       req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              busy,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0_o,
  output logic              flash_io0_oe,
  input  logic              flash_io0_i,
  input  logic              flash_io1_i
`ifdef SPI_FLASH_STREAM_DUAL_EN
  ,
  input  logic              dual_mode
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_RECOV
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REC_W = (CS_HIGH > 1) ? $clog2(CS_HIGH + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(CS_HIGH - 1);
  localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPI_FLASH_STREAM_DUAL_EN
  localparam logic [7:0] CMD_DREAD = 8'h3B;
`endif

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;      // clk cycles spent in the current SCK half-phase
  logic               sck_q, sck_d;
  logic               csb_q, csb_d;
  logic               oe_q, oe_d;
  logic [5:0]         bit_q, bit_d;      // bits done in CMD/ADDR/DUMMY, or within the current word
  logic [31:0]        tx_q, tx_d;        // {command, address}; MSB drives IO0
  logic [DATA_W-1:0]  rx_q, rx_d;        // word being assembled from the flash
  logic [LEN_W-1:0]   words_q, words_d;  // words still to be sampled in this burst
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dvld_q, dvld_d;
  logic               pend_q, pend_d;    // rx_q holds a finished word the buffer could not take
  logic               dual_q, dual_d;

  logic               div_end;
  logic               buf_free;
  logic [5:0]         word_last;
  logic [DATA_W-1:0]  rx_next;
  logic [7:0]         cmd_sel;

`ifndef SPI_FLASH_STREAM_DUAL_EN
  // IO0 is output-only for single reads; the input pin is deliberately ignored.
  logic unused_io0_i;
  assign unused_io0_i = flash_io0_i;
`endif

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_ZERO);
  assign dout_valid   = dvld_q;
  assign dout_data    = dout_q;
  assign flash_csb    = csb_q;
  assign flash_clk    = sck_q;
  assign flash_io0_o  = tx_q[31];
  assign flash_io0_oe = oe_q;

  // Next-state logic for the transaction FSM, SCK generator, shifters and output buffer.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    csb_d    = csb_q;
    oe_d     = oe_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    words_d  = words_q;
    rec_d    = rec_q;
    dout_d   = dout_q;
    dvld_d   = dvld_q & ~dout_ready;
    pend_d   = pend_q;

    div_end   = (div_q == DIV_LAST);
    buf_free  = ~dvld_q | dout_ready;
    word_last = dual_q ? 6'(DATA_W / 2 - 1) : 6'(DATA_W - 1);

`ifdef SPI_FLASH_STREAM_DUAL_EN
    dual_d  = dual_q;
    cmd_sel = dual_mode ? CMD_DREAD : CMD_READ;
    rx_next = dual_q ? {rx_q[DATA_W-3:0], flash_io1_i, flash_io0_i}
                     : {rx_q[DATA_W-2:0], flash_io1_i};
`else
    dual_d  = 1'b0;
    cmd_sel = CMD_READ;
    rx_next = {rx_q[DATA_W-2:0], flash_io1_i};
`endif

    // A parked word moves into the output buffer as soon as the buffer frees up.
    if (pend_q && buf_free) begin
      dout_d = rx_q;
      dvld_d = 1'b1;
      pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          words_d = req_len;
`ifdef SPI_FLASH_STREAM_DUAL_EN
          dual_d  = dual_mode;
`endif
          if (req_len == '0) begin
            state_d = S_ZERO;
          end else begin
            state_d = S_CMD;
            csb_d   = 1'b0;
            sck_d   = 1'b0;
            oe_d    = 1'b1;
            div_d   = '0;
            bit_d   = '0;
            tx_d    = {cmd_sel, req_addr};
          end
        end
      end

      // Zero-length request: a single dead cycle, no flash access.
      S_ZERO: begin
        state_d = S_IDLE;
      end

      S_CMD, S_ADDR, S_DUMMY: begin
        div_d = div_end ? '0 : div_q + DIV_W'(1);
        if (div_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: advance to the next outgoing bit while SCK is low.
            sck_d = 1'b0;
            tx_d  = {tx_q[30:0], 1'b0};
            bit_d = bit_q + 6'd1;
            if (state_q == S_CMD && bit_q == 6'd7) begin
              state_d = S_ADDR;
              bit_d   = '0;
            end else if (state_q == S_ADDR && bit_q == 6'd23) begin
              state_d = dual_q ? S_DUMMY : S_DATA;
              bit_d   = '0;
              oe_d    = 1'b0;
            end else if (state_q == S_DUMMY && bit_q == 6'd7) begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
        end
      end

      S_DATA: begin
        if (sck_q && words_q == '0) begin
          // Last word sampled on the previous edge: stop SCK and release CS.
          state_d = S_RECOV;
          sck_d   = 1'b0;
          csb_d   = 1'b1;
          rec_d   = '0;
          div_d   = '0;
        end else if (!sck_q && div_end && pend_q) begin
          // Shift register still holds an undelivered word: park SCK low.
          div_d = div_q;
        end else begin
          div_d = div_end ? '0 : div_q + DIV_W'(1);
          if (div_end) begin
            if (!sck_q) begin
              sck_d = 1'b1;
              rx_d  = rx_next;
              if (bit_q == word_last) begin
                bit_d   = '0;
                words_d = words_q - LEN_W'(1);
                if (buf_free) begin
                  dout_d = rx_next;
                  dvld_d = 1'b1;
                end else begin
                  pend_d = 1'b1;
                end
              end else begin
                bit_d = bit_q + 6'd1;
              end
            end else begin
              sck_d = 1'b0;
            end
          end
        end
      end

      S_RECOV: begin
        // Hold CS high for CS_HIGH cycles, then wait for the final word to be taken.
        if (rec_q != REC_LAST) begin
          rec_d = rec_q + REC_W'(1);
        end else if (!pend_q && (!dvld_q || dout_ready)) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset parks the flash interface immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      oe_q    <= 1'b0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      words_q <= '0;
      rec_q   <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      pend_q  <= 1'b0;
      dual_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      csb_q   <= csb_d;
      oe_q    <= oe_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      words_q <= words_d;
      rec_q   <= rec_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      pend_q  <= pend_d;
      dual_q  <= dual_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_stream.sv
// Directed bench for spi_flash_stream with a behavioural mode-0 SPI flash model.
`timescale 1ns/1ps
module tb_spi_flash_stream;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [23:0]       req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout_data;
  logic              busy;
  logic              flash_csb;
  logic              flash_clk;
  logic              flash_io0_o;
  logic              flash_io0_oe;
  logic              flash_io0_i = 1'b0;
  logic              flash_io1_i = 1'b0;
`ifdef SPI_FLASH_STREAM_DUAL_EN
  logic              dual_mode = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_flash_stream #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(2), .CS_HIGH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .busy(busy), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_o(flash_io0_o), .flash_io0_oe(flash_io0_oe),
    .flash_io0_i(flash_io0_i), .flash_io1_i(flash_io1_i)
`ifdef SPI_FLASH_STREAM_DUAL_EN
    , .dual_mode(dual_mode)
`endif
  );

  // Flash contents repeat every 8 bytes: DE AD BE EF 01 23 45 67.
  logic [7:0] pat [0:7] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
  int          rb = 0;            // SCK rises in the current CS-low window
  logic [31:0] cap = '0;          // first 32 MOSI bits: command and address
  int          total_rises = 0;
  int          csb_falls = 0;
  time         t_r1 = 0, t_r2 = 0;
  time         t_csb_rise = 0;
  time         min_gap = 64'd1000000000;
  int          accepts = 0;
  int          hs_cnt = 0;
  logic [DATA_W-1:0] hs_last = '0;

  always @(negedge flash_csb) begin
    if ($time - t_csb_rise < min_gap) min_gap = $time - t_csb_rise;
    rb = 0;
    cap = '0;
    csb_falls++;
  end

  always @(posedge flash_csb) t_csb_rise = $time;

  always @(posedge flash_clk) begin
    total_rises++;
    if (flash_csb == 1'b0) begin
      if (rb < 32) cap = {cap[30:0], flash_io0_o};
      rb++;
      if (rb == 1) t_r1 = $time;
      if (rb == 2) t_r2 = $time;
    end
  end

  // Flash shifts out data after each falling SCK once command, address and dummies are in.
  always @(negedge flash_clk) begin
    int j, dummy, p, a;
    logic [7:0] b;
    if (flash_csb == 1'b0 && rb >= 32) begin
      dummy = (cap[31:24] == 8'h3B) ? 8 : 0;
      j = rb - 32 - dummy;
      a = int'(cap[23:0]);
      if (j >= 0) begin
        if (dummy != 0) begin
          p = 2 * j;
          b = pat[(a + p / 8) & 7];
          flash_io1_i = b[7 - (p % 8)];
          flash_io0_i = b[6 - (p % 8)];
        end else begin
          b = pat[(a + j / 8) & 7];
          flash_io1_i = b[7 - (j % 8)];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts++;
    if (dout_valid && dout_ready) begin
      hs_cnt++;
      hs_last = dout_data;
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [LEN_W-1:0] l, input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s: req_ready=%b required 1", nm, req_ready); end
    req_addr = a; req_len = l; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_word(input logic [DATA_W-1:0] exp, input string nm);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while (dout_valid !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++; $display("FAIL %s: dout_valid never rose", nm);
    end else if (dout_data !== exp) begin
      errors++; $display("FAIL %s: dout_data=%h required %h", nm, dout_data, exp);
    end
    @(posedge clk); #1;
    dout_ready = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(req_ready === 1'b1 && busy === 1'b0) && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(req_ready === 1'b1 && busy === 1'b0)) begin
      errors++; $display("FAIL %s: req_ready=%b busy=%b required 1/0", nm, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: %b required 1", req_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: %b required 0", dout_valid); end
    checks++; if (dout_data !== '0) begin errors++; $display("FAIL rst_dout_data: %h required 0", dout_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL rst_csb: %b required 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL rst_sck: %b required 0", flash_clk); end
    checks++; if (flash_io0_o !== 1'b0) begin errors++; $display("FAIL rst_io0: %b required 0", flash_io0_o); end
    checks++; if (flash_io0_oe !== 1'b0) begin errors++; $display("FAIL rst_io0_oe: %b required 0", flash_io0_oe); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int r0;
    r0 = total_rises;
    do_req(24'h000100, 16'd2, "basic_req");
    checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL basic_csb_first_cmd: %b required 0", flash_csb); end
    get_word(32'hDEADBEEF, "basic_w0");
    get_word(32'h01234567, "basic_w1");
    wait_idle("basic_idle");
    checks++; if (cap[31:24] !== 8'h03) begin errors++; $display("FAIL basic_cmd: %h required 03", cap[31:24]); end
    checks++; if (cap[23:0] !== 24'h000100) begin errors++; $display("FAIL basic_addr: %h required 000100", cap[23:0]); end
    checks++; if (total_rises - r0 !== 96) begin errors++; $display("FAIL basic_rises: %0d required 96", total_rises - r0); end
    checks++; if (t_r2 - t_r1 !== 40) begin errors++; $display("FAIL basic_sck_period: %0t required 40ns", t_r2 - t_r1); end
  endtask

  task automatic test_backpressure();
    int r0, r1, n;
    r0 = total_rises;
    dout_ready = 1'b0;
    do_req(24'h000100, 16'd3, "bp_req");
    n = 0;
    while (dout_valid !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: dout_valid=%b required 1", dout_valid); end
    repeat (200) @(posedge clk);
    #1;
    r1 = total_rises;
    repeat (50) @(posedge clk);
    #1;
    checks++; if (total_rises !== r1) begin errors++; $display("FAIL bp_no_edges: %0d extra rises required 0", total_rises - r1); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL bp_sck_low: %b required 0", flash_clk); end
    checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL bp_csb_low: %b required 0", flash_csb); end
    checks++; if (dout_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold_data: %h required deadbeef", dout_data); end
    get_word(32'hDEADBEEF, "bp_w0");
    get_word(32'h01234567, "bp_w1");
    n = 0;
    while (flash_csb !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL bp_burst_end: csb=%b required 1", flash_csb); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_until_taken: busy=%b required 1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_until_taken: req_ready=%b required 0", req_ready); end
    get_word(32'hDEADBEEF, "bp_w2");
    wait_idle("bp_idle");
    checks++; if (total_rises - r0 !== 128) begin errors++; $display("FAIL bp_rises: %0d required 128", total_rises - r0); end
  endtask

  task automatic test_len0();
    int f0;
    f0 = csb_falls;
    do_req(24'h000010, 16'd0, "len0_req");
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL len0_ready_drop: %b required 0", req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL len0_ready_back: %b required 1", req_ready); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (csb_falls !== f0) begin errors++; $display("FAIL len0_csb_falls: %0d required 0", csb_falls - f0); end
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL len0_csb_high: %b required 1", flash_csb); end
  endtask

  task automatic test_reset_mid();
    int n;
    dout_ready = 1'b0;
    do_req(24'h000000, 16'd1, "rmid_req");
    n = 0;
    while (rb < 16 && n < 1000) begin @(posedge clk); #1; n++; end
    checks++; if (rb < 16) begin errors++; $display("FAIL rmid_reach_addr: rises=%0d required >=16", rb); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL rmid_csb: %b required 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL rmid_sck: %b required 0", flash_clk); end
    checks++; if (flash_io0_oe !== 1'b0) begin errors++; $display("FAIL rmid_oe: %b required 0", flash_io0_oe); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_dout_valid: %b required 0", dout_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_req_ready: %b required 1", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(24'h000004, 16'd1, "rmid_req2");
    get_word(32'h01234567, "rmid_word");
    wait_idle("rmid_idle");
  endtask

  task automatic test_back_to_back();
    int acc0, hs0, n;
    acc0 = accepts;
    hs0 = hs_cnt;
    min_gap = 64'd1000000000;
    dout_ready = 1'b1;
    req_addr = 24'h000000; req_len = 16'd1; req_valid = 1'b1;
    n = 0;
    while (accepts < acc0 + 2 && n < 3000) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    wait_idle("b2b_idle");
    dout_ready = 1'b0;
    checks++; if (accepts - acc0 !== 2) begin errors++; $display("FAIL b2b_accepts: %0d required 2", accepts - acc0); end
    checks++; if (hs_cnt - hs0 !== 2) begin errors++; $display("FAIL b2b_words: %0d required 2", hs_cnt - hs0); end
    checks++; if (hs_last !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data: %h required deadbeef", hs_last); end
    checks++; if (min_gap < 40) begin errors++; $display("FAIL b2b_csb_gap: %0t required >=40ns", min_gap); end
  endtask

`ifdef SPI_FLASH_STREAM_DUAL_EN
  task automatic test_dual();
    int r0;
    r0 = total_rises;
    dual_mode = 1'b1;
    do_req(24'h000000, 16'd1, "dual_req");
    dual_mode = 1'b0;
    get_word(32'hDEADBEEF, "dual_word");
    wait_idle("dual_idle");
    checks++; if (cap[31:24] !== 8'h3B) begin errors++; $display("FAIL dual_cmd: %h required 3b", cap[31:24]); end
    checks++; if (total_rises - r0 !== 56) begin errors++; $display("FAIL dual_rises: %0d required 56", total_rises - r0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_reset_mid();
    test_back_to_back();
`ifdef SPI_FLASH_STREAM_DUAL_EN
    test_dual();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
